// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide encodings and sequencer state type, imported by
// the sequencer, the decoder and the hazard unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, fixed 33-cycle latency from accept to done.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(MULDIV_ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_ITERS - 1);

  muldiv_state_t     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic              r_neg;
  logic              r_div0;
  logic [XLEN-1:0]   r_opA;
  logic [XLEN-1:0]   r_opB;
  logic [2*XLEN-1:0] r_acc;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_signA;
  logic              w_signB;
  logic              w_negStart;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic [XLEN:0]     w_mulSum;
  logic [XLEN:0]     w_divShift;
  logic              w_divGe;
  logic [XLEN-1:0]   w_divDiff;
  logic [XLEN-1:0]   w_divRem;
  logic [2*XLEN-1:0] w_accNext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_remd;
  logic [XLEN-1:0]   w_result;

  // MUL shares its low word with every signedness, so only MULH/MULHSU and
  // the signed divides take magnitudes.
  assign w_signA = op_a[XLEN-1] & ((funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
                                   (funct3 == F3_DIV)  | (funct3 == F3_REM));
  assign w_signB = op_b[XLEN-1] & ((funct3 == F3_MULH) | (funct3 == F3_DIV) |
                                   (funct3 == F3_REM));
  assign w_absA = w_signA ? -op_a : op_a;
  assign w_absB = w_signB ? -op_b : op_b;
  assign w_negStart = (funct3 == F3_REM) ? w_signA : (w_signA ^ w_signB);

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign w_mulSum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opB} : '0);

  // Divide: acc = {remainder, dividend/quotient}; modular low-word subtract is
  // exact whenever the compare says the divisor fits.
  assign w_divShift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_divGe    = (w_divShift >= {1'b0, r_opB});
  assign w_divDiff  = w_divShift[XLEN-1:0] - r_opB;
  assign w_divRem   = w_divGe ? w_divDiff : w_divShift[XLEN-1:0];

  assign w_accNext = r_f3[2] ? {w_divRem, r_acc[XLEN-2:0], w_divGe}
                             : {w_mulSum, r_acc[XLEN-1:1]};

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quot = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_remd = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_result = w_prod[XLEN-1:0];
    case (r_f3)
      F3_MULH, F3_MULHSU, F3_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_result = r_div0 ? '1 : w_quot;
      F3_REM, F3_REMU:              w_result = r_div0 ? r_opA : w_remd;
      default:                      w_result = w_prod[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_opA    <= '0;
      r_opB    <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush && (r_state != IDLE)) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !flush) begin
              r_state <= CALC;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_f3    <= funct3;
              r_neg   <= w_negStart;
              r_div0  <= (op_b == '0);
              r_opA   <= op_a;
              r_opB   <= funct3[2] ? w_absB : w_absA;
              r_acc   <= {{XLEN{1'b0}}, (funct3[2] ? w_absA : w_absB)};
            end
          end
          CALC: begin
            r_acc <= w_accNext;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) r_state <= FIN;
          end
          FIN: begin
            r_result <= w_result;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are queued at issue
// and compared against result whenever done pulses.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checkCount = 0;
  int          failCount  = 0;
  int          cycle      = 0;
  int          startCycle = 0;
  logic [31:0] expQ[$];
  string       tagQ[$];

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t dirVecs[11];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (opA),
    .op_b   (opB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          sp;
    longint unsigned up;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f3)
      F3_MUL:    r = a * b;
      F3_MULH:   begin sp = sa * sb; r = sp[63:32]; end
      F3_MULHSU: begin sp = sa * longint'({32'b0, b}); r = sp[63:32]; end
      F3_MULHU:  begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      F3_DIV:    begin if (b == 0) r = 32'hFFFF_FFFF; else begin sp = sa / sb; r = sp[31:0]; end end
      F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    begin if (b == 0) r = a; else begin sp = sa % sb; r = sp[31:0]; end end
      F3_REMU:   r = (b == 0) ? a : a % b;
      default:   r = '0;
    endcase
    return r;
  endfunction

  // Call right after a negedge; leaves at the negedge following the accept edge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected,
                               input string tag, input bit expectDone);
    start  = 1'b1;
    funct3 = f3;
    opA    = a;
    opB    = b;
    if (expectDone) begin
      expQ.push_back(expected);
      tagQ.push_back(tag);
    end
    @(negedge clk);
    start      = 1'b0;
    startCycle = cycle;
  endtask

  task automatic waitDone(input string tag, input bit checkTiming);
    int busyCnt;
    int lat;
    bit seen;
    busyCnt = busy ? 1 : 0;
    lat     = 0;
    seen    = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = cycle - startCycle;
        break;
      end
      busyCnt += busy ? 1 : 0;
    end
    checkOutput({tag, "_doneSeen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd33);
    if (checkTiming) begin
      checkOutput({tag, "_busyCycles"}, 32'(busyCnt), 32'd33);
      checkOutput({tag, "_busyAtDone"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      n += done ? 1 : 0;
    end
  endtask

  always @(negedge clk) begin : scoreboard
    logic [31:0] e;
    string       t;
    if (rst_n && done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(t, result, e);
      end
    end
  end

  initial begin
    int          n;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;

    dirVecs[0]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    dirVecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    dirVecs[2]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    dirVecs[3]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    dirVecs[4]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    dirVecs[5]  = '{F3_DIVU,   32'd100,       32'd7,         32'd14};
    dirVecs[6]  = '{F3_REMU,   32'd100,       32'd7,         32'd2};
    dirVecs[7]  = '{F3_REM,    32'd5,         32'd0,         32'd5};
    dirVecs[8]  = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    dirVecs[9]  = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    dirVecs[10] = '{F3_DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF};

    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = '0;
    opA    = '0;
    opB    = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] MUL 7 x -3 with latency and busy profile");
    applyStimulus(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul7xm3", 1'b1);
    waitDone("mul7xm3", 1'b1);

    $display("[TB] directed multiply/divide vectors");
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      applyStimulus(dirVecs[i].f3, dirVecs[i].a, dirVecs[i].b, dirVecs[i].e,
                    $sformatf("dir%0d_f3_%0d", i, dirVecs[i].f3), 1'b1);
      waitDone($sformatf("dir%0d", i), 1'b0);
    end

    @(negedge clk);
    applyStimulus(F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div5by0", 1'b1);
    waitDone("div5by0", 1'b1);

    $display("[TB] random operations against reference model");
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      @(negedge clk);
      applyStimulus(f3, a, b, refModel(f3, a, b), $sformatf("rand%0d_f3_%0d", i, f3), 1'b1);
      waitDone($sformatf("rand%0d", i), 1'b0);
    end

    $display("[TB] start held while busy is ignored");
    @(negedge clk);
    applyStimulus(F3_DIVU, 32'd1000, 32'd10, 32'd100, "ignoreStart", 1'b1);
    start  = 1'b1;
    funct3 = F3_MUL;
    opA    = 32'd3;
    opB    = 32'd3;
    repeat (5) @(negedge clk);
    start = 1'b0;
    waitDone("ignoreStart", 1'b0);

    $display("[TB] flush during CALC");
    @(negedge clk);
    applyStimulus(F3_MUL, 32'd5, 32'd6, 32'd0, "flushOp", 1'b0);
    repeat (9) @(negedge clk);
    checkOutput("flush_busyBefore", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busyAfter", 32'(busy), 32'd0);
    checkOutput("flush_resultKept", result, 32'd100);
    countDones(40, n);
    checkOutput("flush_noDone", 32'(n), 32'd0);

    start  = 1'b1;
    flush  = 1'b1;
    funct3 = F3_MUL;
    opA    = 32'd2;
    opB    = 32'd2;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flushIdle_busy", 32'(busy), 32'd0);
    countDones(40, n);
    checkOutput("flushIdle_noDone", 32'(n), 32'd0);
    checkOutput("flushIdle_resultKept", result, 32'd100);

    $display("[TB] back-to-back issue from the done cycle");
    @(negedge clk);
    applyStimulus(F3_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, "b2bFirst", 1'b1);
    waitDone("b2bFirst", 1'b0);
    applyStimulus(F3_REMU, 32'd100, 32'd7, 32'd2, "b2bSecond", 1'b1);
    waitDone("b2bSecond", 1'b0);

    $display("[TB] asynchronous reset mid-CALC");
    @(negedge clk);
    applyStimulus(F3_DIV, 32'd100, 32'd3, 32'd0, "rstOp", 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst_busy", 32'(busy), 32'd0);
    checkOutput("midRst_done", 32'(done), 32'd0);
    checkOutput("midRst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    countDones(40, n);
    checkOutput("midRst_noDone", 32'(n), 32'd0);

    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
